matrix_pixel_fetch: RTL and testbench
=====================================

MATRIX_PIXEL_FETCH -- requirements
Module: matrix_pixel_fetch

Interface
REQ-001 Parameter COLUMNS, default 64, pixels per scan row.
REQ-002 Parameter SCAN_ROWS, default 16, scan rows; each RAM word holds top pixel (row r) and bottom pixel (row r+SCAN_ROWS).
REQ-003 Parameter BPC, default 6, bits per colour channel; equals brightness_mask width.
REQ-004 clk_in  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 load_strobe  in  1  one pixel request per high cycle, from the scan pixel-load enable.
REQ-007 column_address  in  6  column of the requested pixel, counts 63 down to 0.
REQ-008 row_address  in  4  scan row currently being clocked out.
REQ-009 brightness_mask  in  BPC  one-hot bit-plane select, MSB first.
REQ-010 swap_req  in  1  level; writer requests a display-buffer flip.
REQ-011 swap_ack  out  1  one-cycle pulse when the flip takes effect.
REQ-012 ram_addr  out  11  {buffer_sel, row_address, column_address}.
REQ-013 ram_rd_en  out  1  read strobe; RAM returns data exactly one cycle after the edge that samples it.
REQ-014 ram_rd_data  in  36  {top R,G,B, bottom R,G,B}, BPC bits each, R in MSBs.
REQ-015 rgb_top  out  3  {R,G,B} bit for the top half.
REQ-016 rgb_bottom  out  3  {R,G,B} bit for the bottom half.
REQ-017 pixel_valid  out  1  high when rgb_top/rgb_bottom carry a fetched pixel.

Function
REQ-018 Three-stage pipeline, one pixel per cycle sustained, no back-pressure.
REQ-019 Stage 1: on load_strobe, register ram_addr and ram_rd_en=1 with captured mask; ram_rd_en=0 otherwise, ram_addr holds.
REQ-020 Stage 2: capture ram_rd_data and the delayed mask in the cycle after ram_rd_en.
REQ-021 Stage 3: per channel, output 1 iff (channel value AND mask) is non-zero; register outputs with pixel_valid=1.
REQ-022 Latency: load_strobe high in cycle N gives pixel_valid and data in cycle N+3.
REQ-023 Outputs not updated by a valid stage 3 hold the last value; pixel_valid is 0.
REQ-024 A mask that is not one-hot (including zero) yields rgb_top=rgb_bottom=0, pixel_valid still 1.
REQ-025 Frame start is defined as load_strobe with row_address=0, column_address=63, and mask MSB set.
REQ-026 swap state machine: IDLE to PENDING when swap_req=1; PENDING to IDLE at frame start, toggling buffer_sel and pulsing swap_ack in the cycle after.
REQ-027 The frame-start pixel is read from the new buffer; no frame mixes buffers.
REQ-028 swap_req asserted during the frame-start cycle while IDLE waits for the next frame start.
REQ-029 swap_req held high after the ack with no drop produces no second flip; a new request needs a low cycle (edge-detected).
REQ-030 Back-to-back load_strobe across row or bit-plane changes needs no bubbles; each pixel uses its own captured mask.

Reset
REQ-031 reset clears buffer_sel=0, swap state IDLE, and swap_ack, ram_rd_en, pixel_valid, rgb_top, rgb_bottom, ram_addr all to 0.
REQ-032 reset mid-pipeline discards in-flight pixels; the first post-reset valid pixel comes 3 cycles after the first new load_strobe.
REQ-033 reset has priority over load_strobe and swap_req in the same cycle.

Structure
REQ-034 Package matrix_pkg holds COLUMNS, SCAN_ROWS, BPC, the RAM word field offsets, and the swap-state enum.
REQ-035 One sub-module, pixel_bit_select: a registered per-channel mask AND/reduce for stage 3.
REQ-036 There is no internal RAM; the framebuffer is external with the port contract above.

Verification
REQ-037 64 consecutive strobes, row 3, mask 6'b100000, RAM word R=6'h20 elsewhere 0 -> 64 valid pixels with rgb_top=3'b100, first at strobe+3.
REQ-038 Same data with mask 6'b000001 -> rgb_top=3'b000; with R=6'h21 -> 3'b100.
REQ-039 swap_req at row 7 -> buffer_sel unchanged until next frame start; ram_addr[10] flips exactly on the frame-start read; one swap_ack pulse.
REQ-040 mask=0 with strobes -> pixel_valid=1, outputs 0.
REQ-041 reset asserted 1 cycle after a strobe -> no pixel_valid from that strobe; all outputs 0 the cycle after reset.
REQ-042 swap_req held high for 3 frames -> exactly one flip and one swap_ack.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants for the LED-matrix pixel fetch path: geometry, RAM word
// layout and the display-buffer swap state encoding.
package matrix_pkg;

  localparam int COLUMNS   = 64;
  localparam int SCAN_ROWS = 16;
  localparam int BPC       = 6;

  // RAM word: {top R, top G, top B, bottom R, bottom G, bottom B}, R in MSBs.
  localparam int TOP_R_LSB = 5 * BPC;
  localparam int TOP_G_LSB = 4 * BPC;
  localparam int TOP_B_LSB = 3 * BPC;
  localparam int BOT_R_LSB = 2 * BPC;
  localparam int BOT_G_LSB = 1 * BPC;
  localparam int BOT_B_LSB = 0;

  typedef enum logic [0:0] {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_t;

endpackage

// File: rtl/pixel_bit_select.sv
// Stage 3: per-channel bit-plane extraction from one RAM word, registered.
// A mask that is not one-hot forces both halves dark but still flags a pixel.
module pixel_bit_select #(
  parameter int BPC = 6
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  input  logic [BPC-1:0]   mask_i,
  input  logic [6*BPC-1:0] word_i,
  output logic [2:0]       rgb_top_o,
  output logic [2:0]       rgb_bottom_o,
  output logic             pixel_valid_o
);

  logic       onehot;
  logic [5:0] hit;
  logic [2:0] rgb_top_q, rgb_bottom_q;
  logic       pixel_valid_q;

  always_comb begin
    onehot = (mask_i != '0) && ((mask_i & (mask_i - BPC'(1))) == '0);
    hit    = '0;
    for (int i = 0; i < 6; i++) begin
      hit[i] = |(word_i[i*BPC +: BPC] & mask_i) & onehot;
    end
  end

  // Colour bits hold their last value between valid pixels.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rgb_top_q     <= '0;
      rgb_bottom_q  <= '0;
      pixel_valid_q <= 1'b0;
    end else begin
      pixel_valid_q <= valid_i;
      if (valid_i) begin
        rgb_top_q    <= hit[5:3];
        rgb_bottom_q <= hit[2:0];
      end
    end
  end

  assign rgb_top_o     = rgb_top_q;
  assign rgb_bottom_o  = rgb_bottom_q;
  assign pixel_valid_o = pixel_valid_q;

endmodule

// File: rtl/matrix_pixel_fetch.sv
// Fetches scan pixels from an external double-buffered framebuffer and emits one
// bit-plane bit per channel. Flow: every load_strobe cycle is one pixel, no back-pressure.
module matrix_pixel_fetch #(
  parameter int COLUMNS   = matrix_pkg::COLUMNS,
  parameter int SCAN_ROWS = matrix_pkg::SCAN_ROWS,
  parameter int BPC       = matrix_pkg::BPC
) (
  input  logic                                       clk_in,
  input  logic                                       reset,
  input  logic                                       load_strobe,
  input  logic [$clog2(COLUMNS)-1:0]                 column_address,
  input  logic [$clog2(SCAN_ROWS)-1:0]               row_address,
  input  logic [BPC-1:0]                             brightness_mask,
  input  logic                                       swap_req,
  output logic                                       swap_ack,
  output logic [$clog2(SCAN_ROWS)+$clog2(COLUMNS):0] ram_addr,
  output logic                                       ram_rd_en,
  input  logic [6*BPC-1:0]                           ram_rd_data,
  output logic [2:0]                                 rgb_top,
  output logic [2:0]                                 rgb_bottom,
  output logic                                       pixel_valid,
  output logic                                       swap_state_dbg
);
  import matrix_pkg::*;

  localparam int COL_W  = $clog2(COLUMNS);
  localparam int ROW_W  = $clog2(SCAN_ROWS);
  localparam int ADDR_W = ROW_W + COL_W + 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLUMNS - 1);

  swap_state_t       state_q, state_d;
  logic              buf_sel_q, buf_sel_d;
  logic              swap_req_q;
  logic              swap_ack_q, swap_ack_d;
  logic              frame_start, req_rise;
  logic              ram_rd_en_q;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [BPC-1:0]    mask1_q, mask1_d, mask2_q;
  logic              s2_valid_q;

  assign frame_start = load_strobe && (row_address == '0) &&
                       (column_address == LAST_COL) && brightness_mask[BPC-1];
  assign req_rise    = swap_req && !swap_req_q;

  always_comb begin
    state_d    = state_q;
    buf_sel_d  = buf_sel_q;
    swap_ack_d = 1'b0;
    case (state_q)
      SWAP_IDLE: begin
        if (req_rise) state_d = SWAP_PENDING;
      end
      SWAP_PENDING: begin
        if (frame_start) begin
          state_d    = SWAP_IDLE;
          buf_sel_d  = ~buf_sel_q;
          swap_ack_d = 1'b1;
        end
      end
      default: state_d = SWAP_IDLE;
    endcase
  end

  // Address uses the post-flip buffer so the frame-start pixel already reads the new frame.
  always_comb begin
    ram_addr_d = ram_addr_q;
    mask1_d    = mask1_q;
    if (load_strobe) begin
      ram_addr_d = {buf_sel_d, row_address, column_address};
      mask1_d    = brightness_mask;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= SWAP_IDLE;
      buf_sel_q   <= 1'b0;
      swap_req_q  <= 1'b0;
      swap_ack_q  <= 1'b0;
      ram_rd_en_q <= 1'b0;
      ram_addr_q  <= '0;
      mask1_q     <= '0;
      mask2_q     <= '0;
      s2_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_sel_q   <= buf_sel_d;
      swap_req_q  <= swap_req;
      swap_ack_q  <= swap_ack_d;
      ram_rd_en_q <= load_strobe;
      ram_addr_q  <= ram_addr_d;
      mask1_q     <= mask1_d;
      mask2_q     <= mask1_q;
      s2_valid_q  <= ram_rd_en_q;
    end
  end

  // RAM data is present while s2_valid_q is high and is captured by stage 3.
  pixel_bit_select #(.BPC(BPC)) u_bit_select (
    .clk_i         (clk_in),
    .reset_i       (reset),
    .valid_i       (s2_valid_q),
    .mask_i        (mask2_q),
    .word_i        (ram_rd_data),
    .rgb_top_o     (rgb_top),
    .rgb_bottom_o  (rgb_bottom),
    .pixel_valid_o (pixel_valid)
  );

  assign swap_ack       = swap_ack_q;
  assign ram_addr       = ram_addr_q;
  assign ram_rd_en      = ram_rd_en_q;
  assign swap_state_dbg = state_q;

endmodule

// File: tb/tb_matrix_pixel_fetch.sv
// Directed bench for matrix_pixel_fetch with a behavioural one-cycle-latency
// framebuffer and a per-cycle expected-output queue.
module tb_matrix_pixel_fetch;

  logic        clk = 1'b0;
  logic        reset, load_strobe, swap_req;
  logic [5:0]  column_address, brightness_mask;
  logic [3:0]  row_address;
  logic        swap_ack, ram_rd_en, pixel_valid, swap_state_dbg;
  logic [10:0] ram_addr;
  logic [35:0] ram_rd_data;
  logic [2:0]  rgb_top, rgb_bottom;

  logic [35:0] mem [0:2047];

  int checks = 0;
  int errors = 0;

  // Per-cycle expectation {pixel_valid, rgb_top, rgb_bottom}, head = current cycle.
  logic [6:0]  exp_q[$];
  logic [5:0]  last_rgb = '0;
  logic        exp_rd_en = 1'b0;
  logic [10:0] exp_addr = '0;
  logic        exp_ack = 1'b0;
  logic        model_buf = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem[ram_addr];

  matrix_pixel_fetch dut (
    .clk_in          (clk),
    .reset           (reset),
    .load_strobe     (load_strobe),
    .column_address  (column_address),
    .row_address     (row_address),
    .brightness_mask (brightness_mask),
    .swap_req        (swap_req),
    .swap_ack        (swap_ack),
    .ram_addr        (ram_addr),
    .ram_rd_en       (ram_rd_en),
    .ram_rd_data     (ram_rd_data),
    .rgb_top         (rgb_top),
    .rgb_bottom      (rgb_bottom),
    .pixel_valid     (pixel_valid),
    .swap_state_dbg  (swap_state_dbg)
  );

  function automatic logic [5:0] pix(input logic [35:0] w, input logic [5:0] m);
    logic oh;
    oh  = $onehot(m);
    pix = {|(w[35:30] & m), |(w[29:24] & m), |(w[23:18] & m),
           |(w[17:12] & m), |(w[11:6] & m),  |(w[5:0] & m)} & {6{oh}};
  endfunction

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: check this cycle, then drive inputs for the next rising edge.
  task automatic tick(input logic rst, input logic s, input logic [3:0] r, input logic [5:0] c,
                      input logic [5:0] m, input logic req, input logic flip);
    logic [6:0]  e;
    logic [10:0] a;
    e = exp_q.pop_front();
    chk("pixel_valid", 11'(pixel_valid), 11'(e[6]));
    chk("rgb_top",     11'(rgb_top),     11'(e[5:3]));
    chk("rgb_bottom",  11'(rgb_bottom),  11'(e[2:0]));
    chk("ram_rd_en",   11'(ram_rd_en),   11'(exp_rd_en));
    chk("ram_addr",    ram_addr,         exp_addr);
    chk("swap_ack",    11'(swap_ack),    11'(exp_ack));
    reset = rst; load_strobe = s; row_address = r; column_address = c;
    brightness_mask = m; swap_req = req;
    if (rst) begin
      exp_q.delete();
      repeat (3) exp_q.push_back(7'd0);
      last_rgb = '0; exp_rd_en = 1'b0; exp_addr = '0; exp_ack = 1'b0; model_buf = 1'b0;
    end else begin
      exp_ack = flip;
      if (flip) model_buf = ~model_buf;
      exp_rd_en = s;
      if (s) begin
        a        = {model_buf, r, c};
        exp_addr = a;
        last_rgb = pix(mem[a], m);
        exp_q.push_back({1'b1, last_rgb});
      end else begin
        exp_q.push_back({1'b0, last_rgb});
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic req);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 4'd0, 6'd0, 6'd0, req, 1'b0);
  endtask

  task automatic frame_start(input logic req, input logic flip);
    tick(1'b0, 1'b1, 4'd0, 6'd63, 6'b100000, req, flip);
  endtask

  initial begin
    logic [5:0] masks [6];
    masks = '{6'b000100, 6'b001000, 6'b000010, 6'b000000, 6'b000101, 6'b000100};
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    reset = 1'b1; load_strobe = 1'b0; swap_req = 1'b0;
    row_address = '0; column_address = '0; brightness_mask = '0;
    repeat (3) exp_q.push_back(7'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    tick(1'b1, 1'b0, 4'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Row 3, top R = 6'h20, MSB plane, full row back to back.
    for (int c = 0; c < 64; c++) begin
      mem[{1'b0, 4'd3, 6'(c)}] = {6'h20, 30'h0};
      mem[{1'b1, 4'd3, 6'(c)}] = {6'h20, 30'h0};
    end
    for (int i = 0; i < 64; i++) tick(1'b0, 1'b1, 4'd3, 6'(63 - i), 6'b100000, 1'b0, 1'b0);
    idle(3, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 4'd3, 6'(63 - i), 6'b000001, 1'b0, 1'b0);
    idle(3, 1'b0);
    for (int c = 0; c < 64; c++) mem[{1'b0, 4'd3, 6'(c)}] = {6'h21, 30'h0};
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 4'd3, 6'(63 - i), 6'b000001, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Row 5: top B = 6'h0C, bottom G = 6'h04; plane changes every pixel incl. zero/non-one-hot.
    for (int c = 0; c < 6; c++) mem[{1'b0, 4'd5, 6'(c)}] = (36'h0C << 18) | (36'h04 << 6);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 4'd5, 6'(5 - i), masks[i], 1'b0, 1'b0);
    idle(3, 1'b0);

    // Buffer 0 frame-start pixel is top R, buffer 1 is top G.
    mem[{1'b0, 4'd0, 6'd63}] = {6'h20, 30'h0};
    mem[{1'b1, 4'd0, 6'd63}] = {6'h00, 6'h20, 24'h0};
    tick(1'b0, 1'b1, 4'd7, 6'd10, 6'b100000, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 4'd7, 6'd9,  6'b100000, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 4'd7, 6'd8,  6'b100000, 1'b0, 1'b0);
    frame_start(1'b0, 1'b1);
    tick(1'b0, 1'b1, 4'd0, 6'd62, 6'b100000, 1'b0, 1'b0);
    idle(3, 1'b0);
    frame_start(1'b0, 1'b0);
    idle(3, 1'b0);

    // Request raised on a frame-start cycle waits for the following frame start.
    frame_start(1'b1, 1'b0);
    idle(2, 1'b0);
    frame_start(1'b0, 1'b1);
    idle(3, 1'b0);

    // Request held high across three frames flips once.
    idle(1, 1'b1);
    frame_start(1'b1, 1'b1);
    idle(2, 1'b1);
    frame_start(1'b1, 1'b0);
    idle(2, 1'b1);
    frame_start(1'b1, 1'b0);
    idle(3, 1'b0);

    // Reset beats a simultaneous strobe and request; buffer returns to 0.
    tick(1'b1, 1'b1, 4'd0, 6'd63, 6'b100000, 1'b1, 1'b0);
    idle(2, 1'b0);
    frame_start(1'b0, 1'b0);
    idle(3, 1'b0);

    // Reset one cycle after a strobe discards it; fresh strobe comes out 3 cycles later.
    tick(1'b0, 1'b1, 4'd3, 6'd5, 6'b100000, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 4'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    idle(4, 1'b0);
    tick(1'b0, 1'b1, 4'd3, 6'd4, 6'b100000, 1'b0, 1'b0);
    idle(4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
